// File: rtl/pwm_peripheral_if.sv
// Register-side inputs and pad-side outputs of the PWM peripheral.
// There is no handshake on this bus: the control registers are level
// signals that are sampled every clk, and the pin drives and period_start
// are updated every clk. Nothing here uses valid or ready.
`timescale 1ns/1ps
interface pwm_peripheral_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] out_7_0;
    logic [7:0] out_15_8;
    logic       period_start;

    // Register file side: drives the controls and observes the pins.
    modport master (
        output en_reg_out_7_0, en_reg_out_15_8,
        output en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out_7_0, out_15_8, period_start
    );

    // Peripheral side.
    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8,
        input  en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out_7_0, out_15_8, period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output stage. Each pin is driven low, driven high, or driven by
// one shared PWM waveform. A prescaler produces a counter tick every
// CLK_DIV clk cycles (CLK_DIV must be at least 1). An 8-bit period counter
// advances on each tick. The duty value goes through a shadow register, so
// a change only takes effect at a period wrap. When no pin is modulating,
// the shadow register loads the new duty value immediately.
`timescale 1ns/1ps
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_peripheral_if.slave  bus
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [7:0]       pwm_cnt;
    logic             wrap;
    logic [7:0]       duty_shadow;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;
    logic [15:0]      pwm_mask;
    logic             pwm_raw;
    logic [15:0]      pin_next;
    logic [15:0]      pins;
    logic             period_start_q;

    assign en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign pwm_mask = en_out & en_pwm;

    assign tick = (div_cnt == DIV_LAST);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    // Duty 0xFF is a special case. Without it the waveform would dip for
    // one tick at count 255.
    assign pwm_raw = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);

    // Pin mux: a pin that is not enabled is low, a static pin is high,
    // and a PWM pin follows the shared waveform.
    assign pin_next = en_out & (~en_pwm | {16{pwm_raw}});

    // Prescaler: free-running count 0..CLK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Period counter: advances once per tick and wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'h00;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'h01;
        end
    end

    // Shadow duty: loads at the period wrap, or at once when no pin is
    // modulating, so that a visible waveform never changes mid-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= 8'h00;
        end else if (wrap || (pwm_mask == 16'h0000)) begin
            duty_shadow <= bus.pwm_duty_cycle;
        end
    end

    // Registered pin drive and period_start pulse. The pulse is high in the
    // cycle where the counter first reads 0 after a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins           <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            pins           <= pin_next;
            period_start_q <= wrap;
        end
    end

    assign bus.out_7_0      = pins[7:0];
    assign bus.out_15_8     = pins[15:8];
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with CLK_DIV = 2 (512 clk per period).
// Inputs change on the falling edge and outputs are sampled there too.
`timescale 1ns/1ps
module tb_pwm_peripheral;

    localparam int CLK_DIV    = 2;
    localparam int PERIOD_CLK = 256 * CLK_DIV;
    localparam int WAIT_LIMIT = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_peripheral_if bus ();

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          num_checks = 0;
    int          num_fail   = 0;
    logic [31:0] exp_q[$];

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog that stops the run if the bench itself stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty);
        bus.en_reg_out_7_0  = eo[7:0];
        bus.en_reg_out_15_8 = eo[15:8];
        bus.en_reg_pwm_7_0  = ep[7:0];
        bus.en_reg_pwm_15_8 = ep[15:8];
        bus.pwm_duty_cycle  = duty;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts clk cycles until period_start is seen. Also counts the samples
    // in which pin 0 is high. The wait gives up at WAIT_LIMIT cycles.
    task automatic wait_period_start(output int n, output int highs);
        n     = 0;
        highs = 0;
        do begin
            step();
            n++;
            if (bus.out_7_0[0]) highs++;
        end while (!bus.period_start && n < WAIT_LIMIT);
    endtask

    task automatic measure_high(input int n_clk, output int highs);
        highs = 0;
        for (int i = 0; i < n_clk; i++) begin
            step();
            if (bus.out_7_0[0]) highs++;
        end
    endtask

    // Scoreboard: measures pin 0 over a window and compares the result
    // against the oldest queued expectation.
    task automatic expect_high(input string tag, input int n_clk);
        int          highs;
        logic [31:0] exp;
        measure_high(n_clk, highs);
        exp = exp_q.pop_front();
        check(tag, highs, exp);
    endtask

    initial begin
        int          n;
        int          h;
        int          ha;
        int          hb;
        logic [7:0]  duty_tab[3];
        logic [31:0] high_tab[3];
        duty_tab = '{8'h00, 8'hFF, 8'h01};
        high_tab = '{32'd0, 32'd1024, 32'd4};

        // Reset.
        drive_regs(16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_out_7_0", bus.out_7_0, 8'h00);
        check("rst_out_15_8", bus.out_15_8, 8'h00);
        check("rst_period_start", bus.period_start, 1'b0);
        rst_n = 1'b1;

        // Idle: first period_start 512 clk after release, then every 512.
        wait_period_start(n, h);
        check("t1_first_start", n, PERIOD_CLK);
        check("t1_pins_low", h, 0);
        wait_period_start(n, h);
        check("t1_second_start", n, PERIOD_CLK);
        step();
        check("t1_pulse_width", bus.period_start, 1'b0);

        // Static high on pins 7..0.
        drive_regs(16'h00FF, 16'h0000, 8'h00);
        step();
        check("t2_out_7_0", bus.out_7_0, 8'hFF);
        check("t2_out_15_8", bus.out_15_8, 8'h00);
        wait_period_start(n, h);
        step();
        check("t2_out_7_0_later", bus.out_7_0, 8'hFF);

        // 50% duty loaded immediately, then pin 0 in PWM mode.
        drive_regs(16'h00FF, 16'h0000, 8'h80);
        step();
        drive_regs(16'h0001, 16'h0001, 8'h80);
        wait_period_start(n, h);
        check("t3_start_gap", n <= PERIOD_CLK, 1'b1);
        check("t3_low_at_start", bus.out_7_0, 8'h00);
        step();
        check("t3_rise", bus.out_7_0, 8'h01);
        exp_q.push_back(32'd256);
        expect_high("t3_high_clk", PERIOD_CLK);

        // Duty edge values, each held for two full periods.
        for (int k = 0; k < 3; k++) begin
            drive_regs(16'h0001, 16'h0001, duty_tab[k]);
            wait_period_start(n, h);
            exp_q.push_back(high_tab[k]);
            expect_high($sformatf("t4_duty_%02h", duty_tab[k]), 2 * PERIOD_CLK);
        end

        // Mid-period duty write only affects the next period.
        drive_regs(16'h0001, 16'h0001, 8'h40);
        wait_period_start(n, h);
        ha = 0;
        hb = 0;
        for (int i = 1; i <= 2 * PERIOD_CLK; i++) begin
            step();
            if (bus.out_7_0[0]) begin
                if (i <= PERIOD_CLK) ha++;
                else hb++;
            end
            if (i == 200) drive_regs(16'h0001, 16'h0001, 8'hC0);
            if (i == PERIOD_CLK) check("t5_wrap_start", bus.period_start, 1'b1);
        end
        check("t5_old_period_high", ha, 128);
        check("t5_new_period_high", hb, 384);

        // Asynchronous reset while outputs are high.
        drive_regs(16'h0101, 16'h0001, 8'hC0);
        wait_period_start(n, h);
        repeat (3) step();
        check("t6_pre_out_7_0", bus.out_7_0, 8'h01);
        check("t6_pre_out_15_8", bus.out_15_8, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_out_7_0", bus.out_7_0, 8'h00);
        check("t6_async_out_15_8", bus.out_15_8, 8'h00);
        check("t6_async_period_start", bus.period_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_period_start(n, h);
        check("t6_first_start", n, PERIOD_CLK);
        check("t6_pwm_low_until_load", h, 0);
        check("t6_static_pin", bus.out_15_8, 8'h01);
        exp_q.push_back(32'd384);
        expect_high("t6_after_load", PERIOD_CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
